neural_frame_packer: RTL and testbench
======================================

# neural_frame_packer

Stage directly downstream of the per-channel acquisition front end. Consumes its one-cycle sample strobes (data, channel ID, valid), collects one sample per enabled channel into a frame, and emits the frame as a header word plus ordered samples on a valid/ready stream toward the transport/DMA stage. A double-buffered capture/emit structure lets a new frame fill while the previous one drains. Frames that complete while the emitter is still busy are dropped and counted.

## Interface
- DATA_WIDTH, 16: sample and output word width; must be ≥ 16.
- CH_ID_WIDTH, 4: channel ID width.
- NUM_CH, 2**CH_ID_WIDTH: number of channels.
- SEQ_WIDTH, 8: frame sequence counter width.
- sensor_clk  in  1  single clock; all logic is on its rising edge.
- sensor_rst  in  1  synchronous, active-high reset.
- acq_data  in  DATA_WIDTH  sample from the front end.
- acq_channel  in  CH_ID_WIDTH  channel of the sample.
- acq_valid  in  1  single-cycle sample strobe; there is no backpressure.
- frame_ch_mask  in  NUM_CH  channels that make up a frame (bit i is channel i).
- out_data  out  DATA_WIDTH  header or sample word.
- out_sof  out  1  high with the header word.
- out_eof  out  1  high with the last sample word.
- out_valid  out  1  word is valid.
- out_ready  in  1  downstream accepts the word.
- frame_drop  out  1  one-cycle pulse when a completed frame is discarded.
- drop_count  out  16  number of dropped frames; saturates at 0xFFFF.

## Operation
- Capture bank: NUM_CH sample registers plus a `seen` bitmask.
- On acq_valid with frame_ch_mask[acq_channel]=1:
  - write the sample into the register for that channel;
  - set the channel's `seen` bit;
  - a repeat sample on an already-seen channel overwrites the register (latest sample wins).
- Samples on masked-off channels are ignored.
- Frame completion:
  - `seen_next` = `seen` including the current sample.
  - The frame completes when (seen_next & mask) == mask and mask ≠ 0.
  - The completing sample is part of the frame.
- On completion:
  - `seen` clears;
  - seq increments modulo 2^SEQ_WIDTH, whether the frame is emitted or dropped, so gaps are visible to the host.
- Emitter free: state IDLE, or the EOF word handshakes in this cycle.
  - If free: copy the capture bank (including the current sample) and the mask into the emit bank, then go to HDR.
  - Otherwise: drop the frame, pulse frame_drop, increment drop_count (saturating).
- mask = 0: no frames complete and `seen` is held at 0.
- A mask change mid-frame takes effect immediately against the current `seen`.
- Emitter FSM:
  - IDLE → HDR on accepted frame.
  - HDR → DATA on handshake.
  - DATA steps through the set bits of the emit mask in ascending channel order, one word per handshake.
  - After the last word handshakes: → HDR if a new frame is accepted in the same cycle, else → IDLE.
- Header word:
  - out_data[15:8] = seq value of that frame (low 8 bits);
  - out_data[7:0] = popcount(emit mask);
  - the remaining upper bits are 0.
- Single-channel frame: the sample word carries out_eof.

## Timing
- Reset values: out_valid, out_sof, out_eof and frame_drop are 0; out_data, drop_count, seq, `seen` and all banks are 0; FSM is IDLE.
- Reset mid-frame or mid-emit abandons everything; no partial frame is emitted afterwards.
- Latency: a completing sample on cycle T gives the header with out_valid on T+1.
- Handshake: a word transfers when out_valid && out_ready.
- While out_valid && !out_ready, out_data, out_sof and out_eof hold stable.
- out_valid never drops without a handshake.
- Back-to-back frames: no bubble between one frame's EOF and the next frame's header when the next frame completes in the EOF handshake cycle.
- frame_drop is registered and asserts on T+1 for a completion on cycle T.
- drop_count updates on the same cycle as frame_drop.

## Structure
- Shared package neural_acq_pkg:
  - frame_state_e (IDLE, HDR, DATA);
  - header field offsets (SEQ_LSB=8, NCH_LSB=0);
  - DROP_CNT_WIDTH=16.
- Sub-module neural_ch_next_sel: combinational next-set-bit finder. Given the emit mask and the current index, returns the next set channel index and a last flag. Used by the DATA state and for the first index on entering DATA.

## Test plan
- Mask 0x000F, samples ch0..ch3 = 0x0100..0x0103, out_ready=1 → header 0x0004 (seq 0) with sof, then 0x0100..0x0103, with eof on 0x0103.
- Mask 0x0005, samples ch2=0xAAAA, ch1=0x1111, ch0=0x5555 → ch1 ignored; header 0x0002, then 0x5555, 0xAAAA.
- Mask 0x0003, ch0=0x0001 then ch0=0x0002 then ch1=0x0003 → frame carries 0x0002, 0x0003 (overwrite).
- out_ready=0 held for 20 cycles while two further frames complete on mask 0x0001 → first frame held stable, two frame_drop pulses, drop_count=2; the next emitted header shows seq 3.
- Completion in the same cycle as the EOF handshake → next header presented on the following cycle with no idle cycle; seq is prior+1.
- sensor_rst asserted while a word is in HDR/DATA → out_valid=0 next cycle, drop_count=0; the next emitted header shows seq 0.

Source files
------------

// File: rtl/neural_acq_pkg.sv
// Shared types and constants for the neural acquisition path: emitter states,
// header field layout and drop counter width.
package neural_acq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } frame_state_e;

    localparam int SEQ_LSB        = 8;
    localparam int NCH_LSB        = 0;
    localparam int HDR_FIELD_W    = 8;
    localparam int DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/neural_ch_next_sel.sv
// Finds the next set channel in a mask at or after a start index, and reports
// whether that channel is the highest set bit (last word of the frame).
module neural_ch_next_sel #(
    parameter int NUM_CH      = 16,
    parameter int CH_ID_WIDTH = 4
) (
    input  logic [NUM_CH-1:0]      mask,
    input  logic [CH_ID_WIDTH-1:0] from_idx,
    input  logic                   inclusive,
    output logic [CH_ID_WIDTH-1:0] next_idx,
    output logic                   next_last
);

    logic found;

    always_comb begin
        next_idx  = '0;
        next_last = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i] && ((i > int'(from_idx)) || (inclusive && (i == int'(from_idx))))) begin
                if (!found) begin
                    next_idx = CH_ID_WIDTH'(i);
                    found    = 1'b1;
                end else begin
                    // another set bit beyond the chosen one: not the last word
                    next_last = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/neural_frame_packer.sv
// Collects one sample per enabled channel into a frame and streams it out as a
// header word plus ordered samples; a second bank lets capture overlap emission.
module neural_frame_packer
    import neural_acq_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CH_ID_WIDTH = 4,
    parameter int NUM_CH      = 2**CH_ID_WIDTH,
    parameter int SEQ_WIDTH   = 8
) (
    input  logic                      sensor_clk,
    input  logic                      sensor_rst,
    input  logic [DATA_WIDTH-1:0]     acq_data,
    input  logic [CH_ID_WIDTH-1:0]    acq_channel,
    input  logic                      acq_valid,
    input  logic [NUM_CH-1:0]         frame_ch_mask,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_drop,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    logic [DATA_WIDTH-1:0]     cap_bank_reg  [NUM_CH];
    logic [DATA_WIDTH-1:0]     emit_bank_reg [NUM_CH];
    logic [NUM_CH-1:0]         seen_reg, seen_next;
    logic [NUM_CH-1:0]         emit_mask_reg;
    logic [NUM_CH-1:0]         sample_onehot;
    logic [SEQ_WIDTH-1:0]      seq_reg, emit_seq_reg;
    logic [CH_ID_WIDTH-1:0]    idx_reg;
    logic                      last_reg;
    logic                      frame_drop_reg;
    logic [DROP_CNT_WIDTH-1:0] drop_count_reg;
    frame_state_e              state_reg, state_next;

    logic                      sample_hit, frame_done, word_fire, eof_fire;
    logic                      emit_free, frame_accept, frame_reject;
    logic [CH_ID_WIDTH-1:0]    sel_from, sel_idx;
    logic                      sel_incl, sel_last;
    logic [HDR_FIELD_W-1:0]    hdr_seq, hdr_nch;

    assign sample_hit    = acq_valid && frame_ch_mask[acq_channel];
    assign sample_onehot = sample_hit ? ({{(NUM_CH-1){1'b0}}, 1'b1} << acq_channel) : '0;
    assign seen_next     = seen_reg | sample_onehot;
    assign frame_done    = (frame_ch_mask != '0) && ((seen_next & frame_ch_mask) == frame_ch_mask);

    assign word_fire    = out_valid && out_ready;
    assign eof_fire     = (state_reg == DATA) && last_reg && word_fire;
    assign emit_free    = (state_reg == IDLE) || eof_fire;
    assign frame_accept = frame_done && emit_free;
    assign frame_reject = frame_done && !emit_free;

    // Per-channel capture and emit registers; the emit copy folds in the
    // completing sample so it is part of the frame.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank
        always_ff @(posedge sensor_clk) begin
            if (sensor_rst) begin
                cap_bank_reg[gi]  <= '0;
                emit_bank_reg[gi] <= '0;
            end else begin
                if (sample_onehot[gi]) begin
                    cap_bank_reg[gi] <= acq_data;
                end
                if (frame_accept) begin
                    emit_bank_reg[gi] <= sample_onehot[gi] ? acq_data : cap_bank_reg[gi];
                end
            end
        end
    end

    always_ff @(posedge sensor_clk) begin
        if (sensor_rst) begin
            seen_reg       <= '0;
            seq_reg        <= '0;
            emit_seq_reg   <= '0;
            emit_mask_reg  <= '0;
            frame_drop_reg <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if ((frame_ch_mask == '0) || frame_done) begin
                seen_reg <= '0;
            end else begin
                seen_reg <= seen_next;
            end
            if (frame_done) begin
                seq_reg <= seq_reg + 1'b1;
            end
            if (frame_accept) begin
                emit_seq_reg  <= seq_reg;
                emit_mask_reg <= frame_ch_mask;
            end
            frame_drop_reg <= frame_reject;
            if (frame_reject && (drop_count_reg != '1)) begin
                drop_count_reg <= drop_count_reg + 1'b1;
            end
        end
    end

    // Header handshake searches from channel 0 inclusive; DATA steps past idx.
    assign sel_incl = (state_reg == HDR);
    assign sel_from = (state_reg == HDR) ? '0 : idx_reg;

    neural_ch_next_sel #(
        .NUM_CH      (NUM_CH),
        .CH_ID_WIDTH (CH_ID_WIDTH)
    ) u_next_sel (
        .mask      (emit_mask_reg),
        .from_idx  (sel_from),
        .inclusive (sel_incl),
        .next_idx  (sel_idx),
        .next_last (sel_last)
    );

    always_ff @(posedge sensor_clk) begin
        if (sensor_rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (word_fire && (state_reg != IDLE)) begin
                idx_reg  <= sel_idx;
                last_reg <= sel_last;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (frame_accept) state_next = HDR;
            HDR:  if (word_fire) state_next = DATA;
            DATA: if (eof_fire) state_next = frame_accept ? HDR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign hdr_seq = HDR_FIELD_W'(emit_seq_reg);
    assign hdr_nch = HDR_FIELD_W'($countones(emit_mask_reg));

    always_comb begin
        out_data = '0;
        if (state_reg == HDR) begin
            out_data[SEQ_LSB +: HDR_FIELD_W] = hdr_seq;
            out_data[NCH_LSB +: HDR_FIELD_W] = hdr_nch;
        end else if (state_reg == DATA) begin
            out_data = emit_bank_reg[idx_reg];
        end
    end

    assign out_valid  = (state_reg != IDLE);
    assign out_sof    = (state_reg == HDR);
    assign out_eof    = (state_reg == DATA) && last_reg;
    assign frame_drop = frame_drop_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_neural_frame_packer.sv
// Directed stimulus with a queue scoreboard; a negedge monitor pops expected
// words on every handshake and checks hold-stability under backpressure.
module tb_neural_frame_packer;

    logic        sensor_clk = 1'b0;
    logic        sensor_rst = 1'b1;
    logic [15:0] acq_data = '0;
    logic [3:0]  acq_channel = '0;
    logic        acq_valid = 1'b0;
    logic [15:0] frame_ch_mask = '0;
    logic [15:0] out_data;
    logic        out_sof, out_eof, out_valid;
    logic        out_ready = 1'b0;
    logic        frame_drop;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    logic [17:0] sb [$];
    logic [17:0] prev_word;
    logic        have_prev = 1'b0;

    always #5 sensor_clk = ~sensor_clk;

    neural_frame_packer dut (
        .sensor_clk    (sensor_clk),
        .sensor_rst    (sensor_rst),
        .acq_data      (acq_data),
        .acq_channel   (acq_channel),
        .acq_valid     (acq_valid),
        .frame_ch_mask (frame_ch_mask),
        .out_data      (out_data),
        .out_sof       (out_sof),
        .out_eof       (out_eof),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .frame_drop    (frame_drop),
        .drop_count    (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge sensor_clk);
        #1;
    endtask

    task automatic push(input logic sof, input logic eof, input logic [15:0] data);
        sb.push_back({sof, eof, data});
    endtask

    task automatic send(input logic [3:0] ch, input logic [15:0] data);
        acq_channel = ch;
        acq_data    = data;
        acq_valid   = 1'b1;
        tick();
        acq_valid   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        sensor_rst = 1'b1;
        acq_valid  = 1'b0;
        tick();
        tick();
        sb.delete();
        sensor_rst = 1'b0;
    endtask

    // Monitor: compare every transferred word; verify stall stability.
    always @(negedge sensor_clk) begin
        if (sensor_rst) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev)
                check("hold_stable", {13'd0, out_valid, out_sof, out_eof, out_data},
                      {13'd0, 1'b1, prev_word});
            have_prev = out_valid && !out_ready;
            prev_word = {out_sof, out_eof, out_data};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h want none", {out_sof, out_eof, out_data});
                end else begin
                    check("out_word", {14'd0, out_sof, out_eof, out_data}, {14'd0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        // reset state
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_sof_eof_drop", {out_sof, out_eof, frame_drop}, 0);
        check("rst_data", out_data, 0);
        check("rst_drop_count", drop_count, 0);
        sensor_rst = 1'b0;

        // 1: four-channel frame
        out_ready = 1'b1;
        frame_ch_mask = 16'h000F;
        push(1, 0, 16'h0004);
        push(0, 0, 16'h0100);
        push(0, 0, 16'h0101);
        push(0, 0, 16'h0102);
        push(0, 1, 16'h0103);
        send(0, 16'h0100);
        send(1, 16'h0101);
        send(2, 16'h0102);
        check("pre_complete_idle", out_valid, 0);
        send(3, 16'h0103);
        check("latency_hdr", {out_valid, out_sof}, 2'b11);
        drain();

        // 2: masked-off channel ignored
        do_reset();
        frame_ch_mask = 16'h0005;
        push(1, 0, 16'h0002);
        push(0, 0, 16'h5555);
        push(0, 1, 16'hAAAA);
        send(2, 16'hAAAA);
        send(1, 16'h1111);
        check("masked_ch_no_frame", out_valid, 0);
        send(0, 16'h5555);
        drain();

        // 3: repeat sample overwrites (seq continues at 1)
        frame_ch_mask = 16'h0003;
        push(1, 0, 16'h0102);
        push(0, 0, 16'h0002);
        push(0, 1, 16'h0003);
        send(0, 16'h0001);
        send(0, 16'h0002);
        send(1, 16'h0003);
        drain();

        // 4: backpressure with two dropped frames
        do_reset();
        out_ready = 1'b0;
        frame_ch_mask = 16'h0001;
        push(1, 0, 16'h0001);
        push(0, 1, 16'h0011);
        send(0, 16'h0011);
        check("no_drop_on_accept", frame_drop, 0);
        send(0, 16'h0022);
        check("drop1_pulse", frame_drop, 1);
        check("drop1_count", drop_count, 1);
        tick();
        check("drop_pulse_single", frame_drop, 0);
        send(0, 16'h0033);
        check("drop2_pulse", frame_drop, 1);
        check("drop2_count", drop_count, 2);
        repeat (16) tick();
        check("stall_hdr", {out_valid, out_sof, out_data}, {1'b1, 1'b1, 16'h0001});
        out_ready = 1'b1;
        drain();
        push(1, 0, 16'h0301);
        push(0, 1, 16'h0044);
        send(0, 16'h0044);
        drain();
        check("drop_count_kept", drop_count, 2);

        // 5: next frame completes in the EOF handshake cycle (seq 4 then 5)
        frame_ch_mask = 16'h0003;
        push(1, 0, 16'h0402);
        push(0, 0, 16'h00B0);
        push(0, 1, 16'h00B1);
        push(1, 0, 16'h0502);
        push(0, 0, 16'h00C0);
        push(0, 1, 16'h00C1);
        send(0, 16'h00B0);
        send(1, 16'h00B1);
        send(0, 16'h00C0);
        tick();
        check("b2b_eof_shown", {out_valid, out_eof, out_data}, {1'b1, 1'b1, 16'h00B1});
        send(1, 16'h00C1);
        check("b2b_no_bubble", {out_valid, out_sof, out_data}, {1'b1, 1'b1, 16'h0502});
        check("b2b_no_drop", frame_drop, 0);
        drain();

        // 6: reset while emitting abandons the frame
        out_ready = 1'b0;
        frame_ch_mask = 16'h0001;
        push(1, 0, 16'h0601);
        push(0, 1, 16'h0066);
        send(0, 16'h0066);
        check("pre_rst_valid", out_valid, 1);
        sensor_rst = 1'b1;
        tick();
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_drop_count", drop_count, 0);
        sb.delete();
        tick();
        sensor_rst = 1'b0;
        out_ready  = 1'b1;
        tick();
        check("rst_no_partial", out_valid, 0);
        push(1, 0, 16'h0001);
        push(0, 1, 16'h0077);
        send(0, 16'h0077);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
